// File: rtl/reduction_tile_feeder.sv
// Buffers partial-sum tiles and sequences reduction_accumulator groups:
// one clear cycle, exactly N tiles, then wait for the accumulator result.
module reduction_tile_feeder #(
    parameter int TILE_SIZE  = 4,
    parameter int ACC_WIDTH  = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_TILES  = 16
) (
    input  logic                                                    clk,
    input  logic                                                    rst,
    input  logic [$clog2(MAX_TILES+1)-1:0]                          cfg_tiles,
    input  logic [1:0]                                              cfg_mode,
    input  logic                                                    s_valid,
    output logic                                                    s_ready,
    input  logic signed [TILE_SIZE-1:0][TILE_SIZE-1:0][ACC_WIDTH-1:0] s_mat,
    output logic [1:0]                                              acc_mode,
    output logic                                                    acc_clear,
    output logic                                                    acc_valid,
    output logic signed [TILE_SIZE-1:0][TILE_SIZE-1:0][ACC_WIDTH-1:0] acc_mat,
    input  logic                                                    acc_done,
    output logic                                                    busy,
    output logic                                                    group_done,
    output logic                                                    err_stray
);
    localparam int CW = $clog2(MAX_TILES + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef logic signed [TILE_SIZE-1:0][TILE_SIZE-1:0][ACC_WIDTH-1:0] tile_t;
    typedef enum logic [1:0] {IDLE, CLEAR, ISSUE, WAIT_RES} state_t;

    state_t        state, state_nxt;
    tile_t         mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          empty, full, push, pop, last_pop;
    logic [CW-1:0] n_eff, n_lat, issued;

    // Pointers carry one extra wrap bit to tell full from empty
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign s_ready = !full && !rst;
    assign push  = s_valid && s_ready;
    assign pop   = ((state == CLEAR) || (state == ISSUE)) && !empty && (issued < n_lat);
    assign last_pop = pop && ((issued + CW'(1)) == n_lat);

    always_comb begin
        n_eff = cfg_tiles;
        if (cfg_tiles == '0)
            n_eff = CW'(1);
        else if (cfg_tiles > CW'(MAX_TILES))
            n_eff = CW'(MAX_TILES);
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= s_mat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (!empty) state_nxt = CLEAR;
            CLEAR:    state_nxt = last_pop ? WAIT_RES : ISSUE;
            ISSUE:    if (last_pop) state_nxt = WAIT_RES;
            WAIT_RES: if (acc_done) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        acc_clear = (state == CLEAR);
        busy      = (state != IDLE);
    end

    // Group config is captured only on the IDLE->CLEAR edge
    always_ff @(posedge clk) begin
        if (rst) begin
            n_lat    <= CW'(1);
            acc_mode <= 2'b00;
        end else if (state == IDLE && !empty) begin
            n_lat    <= n_eff;
            acc_mode <= cfg_mode;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issued     <= '0;
            acc_valid  <= 1'b0;
            acc_mat    <= '0;
            group_done <= 1'b0;
            err_stray  <= 1'b0;
        end else begin
            acc_valid  <= pop;
            group_done <= (state == WAIT_RES) && acc_done;
            if (pop) begin
                acc_mat <= mem[rd_ptr[AW-1:0]];
                issued  <= issued + CW'(1);
            end else if (state == WAIT_RES && acc_done) begin
                issued  <= '0;
            end
            if (acc_done && state != WAIT_RES)
                err_stray <= 1'b1;
        end
    end
endmodule

// File: tb/tb_reduction_tile_feeder.sv
// Directed bench for reduction_tile_feeder: group sequencing, backpressure,
// bubbles, config latching, stray results and mid-group reset.
module tb_reduction_tile_feeder;
    localparam int TS = 4;
    localparam int AWD = 32;
    typedef logic signed [TS-1:0][TS-1:0][AWD-1:0] tile_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  cfg_tiles = 5'd1;
    logic [1:0]  cfg_mode = 2'b00;
    logic        s_valid = 1'b0;
    logic        s_ready;
    tile_t       s_mat = '0;
    logic [1:0]  acc_mode;
    logic        acc_clear, acc_valid;
    tile_t       acc_mat;
    logic        acc_done = 1'b0;
    logic        busy, group_done, err_stray;

    int checks = 0;
    int errors = 0;

    reduction_tile_feeder #(.TILE_SIZE(TS), .ACC_WIDTH(AWD), .FIFO_DEPTH(4), .MAX_TILES(16)) dut (
        .clk(clk), .rst(rst), .cfg_tiles(cfg_tiles), .cfg_mode(cfg_mode),
        .s_valid(s_valid), .s_ready(s_ready), .s_mat(s_mat),
        .acc_mode(acc_mode), .acc_clear(acc_clear), .acc_valid(acc_valid), .acc_mat(acc_mat),
        .acc_done(acc_done), .busy(busy), .group_done(group_done), .err_stray(err_stray)
    );

    always #5 clk = ~clk;

    function automatic tile_t mk(input int base);
        tile_t t;
        for (int i = 0; i < TS; i++)
            for (int j = 0; j < TS; j++)
                t[i][j] = base + i * 10 + j;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Clear and valid must never overlap
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            assert (!(acc_clear && acc_valid)) else begin
                errors++;
                $error("FAIL clr_vld_overlap: observed 1 expected 0");
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1;
        chk("rst_s_ready", s_ready, 0);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_ready", s_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_clear", acc_clear, 0);
        chk("rst_valid", acc_valid, 0);
        chk("rst_mat", acc_mat == '0, 1);
        chk("rst_mode", acc_mode, 0);
        chk("rst_err", err_stray, 0);
        chk("rst_gdone", group_done, 0);

        // Single group, N=1
        cfg_tiles = 5'd1;
        s_valid = 1'b1; s_mat = mk(0);
        tick();
        s_valid = 1'b0;
        chk("n1_noclr_early", acc_clear, 0);
        tick();
        chk("n1_clear", acc_clear, 1);
        chk("n1_busy", busy, 1);
        chk("n1_novalid", acc_valid, 0);
        tick();
        chk("n1_clear_1cyc", acc_clear, 0);
        chk("n1_valid", acc_valid, 1);
        chk("n1_mat23", acc_mat[2][3], 23);
        tick();
        chk("n1_valid_drop", acc_valid, 0);
        chk("n1_wait_busy", busy, 1);
        acc_done = 1'b1;
        tick();
        acc_done = 1'b0;
        chk("n1_gdone", group_done, 1);
        chk("n1_idle", busy, 0);
        tick();
        chk("n1_gdone_pulse", group_done, 0);

        // N=4 back-to-back, mode 01, mode changed mid-group
        cfg_tiles = 5'd4; cfg_mode = 2'b01;
        s_valid = 1'b1; s_mat = mk(0);
        tick();
        chk("n4_noclr", acc_clear, 0);
        s_mat = mk(100);
        tick();
        chk("n4_clear", acc_clear, 1);
        chk("n4_mode", acc_mode, 2'b01);
        s_mat = mk(200);
        tick();
        cfg_mode = 2'b10;
        chk("n4_v0", acc_valid, 1);
        chk("n4_t0", acc_mat[0][0], 0);
        s_mat = mk(300);
        tick();
        chk("n4_v1", acc_valid, 1);
        chk("n4_t1", acc_mat[0][0], 100);
        s_valid = 1'b0;
        tick();
        chk("n4_v2", acc_valid, 1);
        chk("n4_t2", acc_mat[0][0], 200);
        chk("n4_noclr2", acc_clear, 0);
        tick();
        chk("n4_v3", acc_valid, 1);
        chk("n4_t3", acc_mat[0][0], 300);
        chk("n4_mode_held", acc_mode, 2'b01);
        tick();
        chk("n4_done_valid", acc_valid, 0);
        chk("n4_noclr3", acc_clear, 0);
        chk("n4_wait", busy, 1);
        acc_done = 1'b1;
        tick();
        acc_done = 1'b0;
        chk("n4_gdone", group_done, 1);

        // Backpressure: N=2, six tiles, result withheld
        cfg_tiles = 5'd2; cfg_mode = 2'b00;
        for (int k = 0; k < 6; k++) begin
            chk("bp_ready", s_ready, 1);
            s_valid = 1'b1; s_mat = mk(1000 + k * 100);
            tick();
            if (k == 2) chk("bp_t0", acc_mat[0][0], 1000);
            if (k == 3) chk("bp_t1", acc_mat[0][0], 1100);
            if (k == 4) chk("bp_wait_novalid", acc_valid, 0);
        end
        s_valid = 1'b0;
        chk("bp_full", s_ready, 0);
        chk("bp_busy", busy, 1);
        tick();
        chk("bp_full_hold", s_ready, 0);
        chk("bp_noclr", acc_clear, 0);
        acc_done = 1'b1;
        tick();
        acc_done = 1'b0;
        chk("bp_gdone", group_done, 1);
        tick();
        chk("g2_clear", acc_clear, 1);
        tick();
        chk("g2_t2", acc_mat[0][0], 1200);
        chk("g2_ready", s_ready, 1);
        tick();
        chk("g2_v3", acc_valid, 1);
        chk("g2_t3", acc_mat[0][0], 1300);
        tick();
        chk("g2_end", acc_valid, 0);
        acc_done = 1'b1;
        tick();
        acc_done = 1'b0;
        cfg_tiles = 5'd4;

        // Starved group of 4 with cfg changed to 2 mid-group
        tick();
        chk("g3_clear", acc_clear, 1);
        tick();
        chk("g3_t4", acc_mat[0][0], 1400);
        tick();
        chk("g3_t5", acc_mat[0][0], 1500);
        tick();
        chk("g3_bubble", acc_valid, 0);
        chk("g3_bub_noclr", acc_clear, 0);
        chk("g3_bub_busy", busy, 1);
        cfg_tiles = 5'd2;
        s_valid = 1'b1; s_mat = mk(1600);
        tick();
        chk("g3_bubble2", acc_valid, 0);
        s_mat = mk(1700);
        tick();
        chk("g3_v6", acc_valid, 1);
        chk("g3_t6", acc_mat[0][0], 1600);
        s_valid = 1'b0;
        tick();
        chk("g3_t7", acc_mat[0][0], 1700);
        tick();
        chk("g3_end", acc_valid, 0);
        chk("g3_wait", busy, 1);
        acc_done = 1'b1; s_valid = 1'b1; s_mat = mk(1800);
        tick();
        acc_done = 1'b0; s_mat = mk(1900);
        chk("g3_gdone", group_done, 1);
        tick();
        chk("g4_clear", acc_clear, 1);
        s_mat = mk(2000);
        tick();
        chk("g4_t8", acc_mat[0][0], 1800);
        s_valid = 1'b0;
        tick();
        chk("g4_t9", acc_mat[0][0], 1900);
        tick();
        chk("g4_n2_stop", acc_valid, 0);
        chk("g4_wait", busy, 1);
        acc_done = 1'b1;
        tick();
        acc_done = 1'b0;
        cfg_tiles = 5'd0;

        // cfg_tiles=0 behaves as one tile
        tick();
        chk("z_clear", acc_clear, 1);
        tick();
        chk("z_valid", acc_valid, 1);
        chk("z_t10", acc_mat[0][0], 2000);
        tick();
        chk("z_one_only", acc_valid, 0);
        chk("z_wait", busy, 1);
        acc_done = 1'b1;
        tick();
        acc_done = 1'b0;
        chk("z_gdone", group_done, 1);
        tick();
        chk("z_idle", busy, 0);

        // Stray results in IDLE and ISSUE
        chk("st_pre", err_stray, 0);
        acc_done = 1'b1;
        tick();
        acc_done = 1'b0;
        chk("st_idle_err", err_stray, 1);
        chk("st_idle_busy", busy, 0);
        chk("st_idle_gdone", group_done, 0);
        cfg_tiles = 5'd2;
        s_valid = 1'b1; s_mat = mk(3000);
        tick();
        s_mat = mk(3100);
        tick();
        chk("st_clear", acc_clear, 1);
        s_valid = 1'b0;
        tick();
        chk("st_t0", acc_mat[0][0], 3000);
        acc_done = 1'b1;
        tick();
        acc_done = 1'b0;
        chk("st_t1", acc_mat[0][0], 3100);
        chk("st_v1", acc_valid, 1);
        tick();
        chk("st_wait", busy, 1);
        chk("st_no_gdone", group_done, 0);
        chk("st_sticky", err_stray, 1);
        acc_done = 1'b1;
        tick();
        acc_done = 1'b0;
        chk("st_gdone", group_done, 1);

        // Reset mid-group with two tiles buffered
        cfg_tiles = 5'd4;
        s_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s_mat = mk(4000 + k * 100);
            tick();
        end
        chk("mr_t1", acc_mat[0][0], 4100);
        s_valid = 1'b0; rst = 1'b1;
        #1;
        chk("mr_ready_in_rst", s_ready, 0);
        tick();
        rst = 1'b0;
        chk("mr_valid", acc_valid, 0);
        chk("mr_clear", acc_clear, 0);
        chk("mr_busy", busy, 0);
        chk("mr_err", err_stray, 0);
        chk("mr_mat", acc_mat == '0, 1);
        tick();
        chk("mr_empty", busy, 0);
        s_valid = 1'b1; s_mat = mk(5000);
        tick();
        s_valid = 1'b0;
        tick();
        chk("mr_fresh_clear", acc_clear, 1);
        tick();
        chk("mr_fresh_t", acc_mat[2][3], 5023);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
